// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NREQ requesters, with bus lock.
// Grant and memory access are combinational in the request cycle; read data returns one cycle later; losers stall by holding req.
module mem_port_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 16,
   parameter int DW   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {FREE, LOCKED} lock_state_e;

   lock_state_e     state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   lock_owner_q, lock_owner_d;
   logic [NREQ-1:0] rvalid_q, rvalid_d;

   logic            win_vld;
   logic [PW-1:0]   win_idx;

   // Lock owner wins outright; otherwise scan from ptr. Reverse loop so the first hit from ptr overrides.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      if (state_q == LOCKED && req[lock_owner_q]) begin
         win_vld = 1'b1;
         win_idx = lock_owner_q;
      end else begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % NREQ]) begin
               win_vld = 1'b1;
               win_idx = PW'((int'(ptr_q) + k) % NREQ);
            end
         end
      end
      if (!rst_n) begin
         win_vld = 1'b0;
      end
   end

   always_comb begin
      gnt       = '0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_vld && win_idx == PW'(i)) begin
            gnt[i]    = 1'b1;
            mem_we    = we[i];
            mem_addr  = addr[i*AW +: AW];
            mem_wdata = wdata[i*DW +: DW];
         end
      end
   end

   assign mem_en = win_vld;
   assign rvalid = rvalid_q;
   assign rdata  = mem_rdata;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      lock_owner_d = lock_owner_q;
      rvalid_d     = '0;
      if (win_vld) begin
         if (!lock[win_idx]) begin
            ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (!we[win_idx]) begin
            rvalid_d[win_idx] = 1'b1;
         end
      end
      case (state_q)
         FREE: begin
            if (win_vld && lock[win_idx]) begin
               state_d      = LOCKED;
               lock_owner_d = win_idx;
            end
         end
         LOCKED: begin
            // Owner dropped its request: this cycle arbitrated normally and may start a new lock.
            if (!req[lock_owner_q]) begin
               state_d = FREE;
               if (win_vld && lock[win_idx]) begin
                  state_d      = LOCKED;
                  lock_owner_d = win_idx;
               end
            end else if (!lock[lock_owner_q]) begin
               state_d = FREE;
            end
         end
         default: state_d = FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= FREE;
         ptr_q        <= '0;
         lock_owner_q <= '0;
         rvalid_q     <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         lock_owner_q <= lock_owner_d;
         rvalid_q     <= rvalid_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-table bench for mem_port_arbiter with a read-return scoreboard and a behavioural memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req, we, lock;
   logic [47:0] addr;
   logic [95:0] wdata;
   logic [2:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NREQ(3), .AW(16), .DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .lock      (lock),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Memory macro model (driven by DUT) and the bench's own reference copy.
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   typedef struct {
      string       name;
      logic        rst_n;
      logic [2:0]  req, we, lock;
      logic [47:0] addr;
      logic [95:0] wdata;
      logic [2:0]  gnt;
   } vec_t;

   typedef struct {
      logic [2:0]  rv;
      logic [31:0] rd;
   } rexp_t;

   rexp_t sb[$];
   vec_t  vecs[$];
   int    n_chk = 0;
   int    n_fail = 0;

   localparam logic [47:0] A_DEF = {16'h0010, 16'h0002, 16'h0001};
   localparam logic [95:0] W_DEF = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

   function automatic vec_t mk(string nm, logic r, logic [2:0] rq, logic [2:0] w, logic [2:0] lk,
                               logic [47:0] a, logic [95:0] d, logic [2:0] g);
      vec_t v;
      v.name = nm; v.rst_n = r; v.req = rq; v.we = w; v.lock = lk;
      v.addr = a; v.wdata = d; v.gnt = g;
      return v;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_cycle(vec_t v);
      int    w;
      rexp_t e;
      @(posedge clk);
      #1;
      rst_n = v.rst_n; req = v.req; we = v.we; lock = v.lock; addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      w = 0;
      for (int i = 0; i < 3; i++) if (v.gnt[i]) w = i;
      chk({v.name, " gnt"}, 64'(gnt), 64'(v.gnt));
      chk({v.name, " mem_en"}, 64'(mem_en), 64'(|v.gnt));
      if (|v.gnt) begin
         chk({v.name, " mem_we"}, 64'(mem_we), 64'(v.we[w]));
         chk({v.name, " mem_addr"}, 64'(mem_addr), 64'(v.addr[w*16 +: 16]));
         chk({v.name, " mem_wdata"}, 64'(mem_wdata), 64'(v.wdata[w*32 +: 32]));
      end
      e.rv = '0; e.rd = '0;
      if (sb.size() != 0) e = sb.pop_front();
      chk({v.name, " rvalid"}, 64'(rvalid), 64'(e.rv));
      if (e.rv != 3'b000) chk({v.name, " rdata"}, 64'(rdata), 64'(e.rd));
      if (!v.rst_n) begin
         sb.delete();
      end else if (|v.gnt) begin
         if (v.we[w]) ref_mem[v.addr[w*16 + 0 +: 8]] = v.wdata[w*32 +: 32];
         else begin
            e.rv = v.gnt;
            e.rd = ref_mem[v.addr[w*16 +: 8]];
            sb.push_back(e);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = {16'hA5A5, 16'(i)};
         ref_mem[i] = {16'hA5A5, 16'(i)};
      end
      mem[8'h10]     = 32'hDEADBEEF;
      ref_mem[8'h10] = 32'hDEADBEEF;
      mem_rdata = '0;
      rst_n = 1'b0; req = '0; we = '0; lock = '0; addr = A_DEF; wdata = W_DEF;
      repeat (2) @(posedge clk);

      vecs.push_back(mk("reset",     1'b0, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));
      vecs.push_back(mk("rr0",       1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b001));
      vecs.push_back(mk("rr1",       1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b010));
      vecs.push_back(mk("rr2",       1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b100));
      vecs.push_back(mk("rr3",       1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b001));
      vecs.push_back(mk("rr4",       1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b010));
      vecs.push_back(mk("rd_lat",    1'b1, 3'b100, 3'b000, 3'b000, A_DEF, W_DEF, 3'b100));
      vecs.push_back(mk("write",     1'b1, 3'b010, 3'b010, 3'b000, {16'h0010, 16'h0020, 16'h0001},
                        {32'hCCCC0002, 32'h12345678, 32'hAAAA0000}, 3'b010));
      vecs.push_back(mk("idle0",     1'b1, 3'b000, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));
      vecs.push_back(mk("rd_back",   1'b1, 3'b010, 3'b000, 3'b000, {16'h0010, 16'h0020, 16'h0001}, W_DEF, 3'b010));
      vecs.push_back(mk("idle1",     1'b1, 3'b000, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));
      vecs.push_back(mk("reset2",    1'b0, 3'b000, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk("lock_hold", 1'b1, 3'b111, 3'b000, 3'b001, A_DEF, W_DEF, 3'b001));
      vecs.push_back(mk("lock_rel",  1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b001));
      vecs.push_back(mk("post_rel1", 1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b010));
      vecs.push_back(mk("post_rel2", 1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b100));
      vecs.push_back(mk("lock1",     1'b1, 3'b010, 3'b000, 3'b010, A_DEF, W_DEF, 3'b010));
      vecs.push_back(mk("lock1_stall", 1'b1, 3'b111, 3'b000, 3'b010, A_DEF, W_DEF, 3'b010));
      vecs.push_back(mk("lock1_drop",  1'b1, 3'b101, 3'b000, 3'b000, A_DEF, W_DEF, 3'b001));
      vecs.push_back(mk("after_drop",  1'b1, 3'b111, 3'b000, 3'b000, A_DEF, W_DEF, 3'b010));
      vecs.push_back(mk("idle2",     1'b1, 3'b000, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));

      foreach (vecs[i]) do_cycle(vecs[i]);

      // Reset asserted before the edge that would return a granted read.
      do_cycle(mk("mid_read", 1'b1, 3'b010, 3'b000, 3'b000, A_DEF, W_DEF, 3'b010));
      rst_n = 1'b0;
      sb.delete();
      do_cycle(mk("mid_rst",  1'b0, 3'b000, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));
      do_cycle(mk("rst_rel",  1'b1, 3'b110, 3'b000, 3'b000, A_DEF, W_DEF, 3'b010));
      do_cycle(mk("drain",    1'b1, 3'b000, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));
      do_cycle(mk("drain2",   1'b1, 3'b000, 3'b000, 3'b000, A_DEF, W_DEF, 3'b000));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
